// File: rtl/serial_adder_ctrl.sv
// Sequences one CHUNK-bit adder slice over WIDTH-bit operands, LSB slice first.
// Operands arrive by valid/ready; the WIDTH+1-bit result leaves by valid/ready.
//
// state | meaning
// IDLE  | waiting for an operation (in_ready high)
// RUN   | adding one slice per clock (busy high)
// DONE  | result held on sum_out until out_ready (out_valid high)
module serial_adder_ctrl #(
    parameter int CHUNK      = 3,
    parameter int NUM_CHUNKS = 4,
    localparam int WIDTH     = CHUNK * NUM_CHUNKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum_out,
    output logic             busy
);
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WIDTH:0]    result_q, result_nxt;
    logic              rdy_q;
    logic [CHUNK-1:0]  a_sl, b_sl;
    logic [CHUNK:0]    slice_sum;
    logic              accept;
    logic              last_slice;

    assign accept     = in_valid & rdy_q;
    assign last_slice = (idx_q == LAST_IDX);
    assign a_sl       = a_q[idx_q*CHUNK +: CHUNK];
    assign b_sl       = b_q[idx_q*CHUNK +: CHUNK];
    assign slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};

    assign in_ready  = rdy_q;
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign sum_out   = result_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The previous result stays visible until the first slice of the next operation lands.
    always_comb begin
        result_nxt = (idx_q == '0) ? '0 : result_q;
        result_nxt[idx_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        if (last_slice) result_nxt[WIDTH] = slice_sum[CHUNK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rdy_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a_in;
                        b_q     <= sub ? ~b_in : b_in;
                        carry_q <= sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    result_q <= result_nxt;
                    carry_q  <= slice_sum[CHUNK];
                    idx_q    <= last_slice ? '0 : idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed vector table, multi-cycle corner sequences and a random regression
// for serial_adder_ctrl at default parameters (12-bit operands, 3-bit slices).
module tb_serial_adder_ctrl;
    localparam int W = 12;

    logic          clk, rst_n;
    logic          in_valid, in_ready, sub, out_valid, out_ready, busy;
    logic [W-1:0]  a_in, b_in;
    logic [W:0]    sum_out;

    int n_vec = 0;
    int n_err = 0;

    serial_adder_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum_out(sum_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W:0]   exp;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] d;
        if (!s) return {1'b0, a} + {1'b0, b};
        d = a - b;
        return {(a >= b), d};
    endfunction

    task automatic wait_ready(input string nm);
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) chk({nm, " ready timeout"}, 0, 1);
    endtask

    // Full operation with out_ready high: checks accept, 4-cycle latency, result, handback.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W:0] exp, input string nm);
        out_ready = 1'b1;
        wait_ready(nm);
        a_in = a; b_in = b; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({nm, " in_ready after accept"}, in_ready, 0);
        for (int c = 0; c < 4; c++) begin
            chk({nm, " busy in run"}, busy, 1);
            chk({nm, " out_valid in run"}, out_valid, 0);
            tick();
        end
        chk({nm, " out_valid"}, out_valid, 1);
        chk({nm, " busy in done"}, busy, 0);
        chk({nm, " sum_out"}, sum_out, exp);
        tick();
        chk({nm, " in_ready after transfer"}, in_ready, 1);
        chk({nm, " out_valid after transfer"}, out_valid, 0);
    endtask

    initial begin
        vecs[0]  = '{12'h0FF, 12'h001, 1'b0, 13'h0100};
        vecs[1]  = '{12'hFFF, 12'h001, 1'b0, 13'h1000};
        vecs[2]  = '{12'h005, 12'h007, 1'b1, 13'h0FFE};
        vecs[3]  = '{12'h007, 12'h005, 1'b1, 13'h1002};
        vecs[4]  = '{12'h123, 12'h456, 1'b0, 13'h0579};
        vecs[5]  = '{12'hFFF, 12'hFFF, 1'b0, 13'h1FFE};
        vecs[6]  = '{12'h000, 12'h000, 1'b0, 13'h0000};
        vecs[7]  = '{12'h000, 12'h000, 1'b1, 13'h1000};
        vecs[8]  = '{12'hABC, 12'hABC, 1'b1, 13'h1000};
        vecs[9]  = '{12'h000, 12'h001, 1'b1, 13'h0FFF};
        vecs[10] = '{12'h800, 12'h800, 1'b0, 13'h1000};
        vecs[11] = '{12'h555, 12'hAAA, 1'b0, 13'h0FFF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        a_in = '0; b_in = '0;
        tick(); tick();
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset sum_out", sum_out, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", in_ready, 0);
        tick();
        chk("in_ready after release", in_ready, 1);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

        // Backpressure: DONE held, result stable, new requests ignored.
        out_ready = 1'b0;
        wait_ready("bp");
        a_in = 12'h3A5; b_in = 12'h0C3; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp out_valid", out_valid, 1);
            chk("bp in_ready", in_ready, 0);
            chk("bp sum_out", sum_out, 13'h0468);
            in_valid = c[0];
            a_in = W'($urandom);
            b_in = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp release in_ready", in_ready, 1);
        chk("bp release out_valid", out_valid, 0);
        tick();
        chk("bp no stray accept", busy, 0);

        // Operand hold-off: inputs churn during RUN.
        wait_ready("hold");
        a_in = 12'h0FF; b_in = 12'h001; sub = 1'b0; in_valid = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            a_in = W'($urandom);
            b_in = W'($urandom);
            sub  = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("hold out_valid", out_valid, 1);
        chk("hold sum_out", sum_out, 13'h0100);
        tick();

        // Asynchronous reset during the second RUN cycle.
        wait_ready("rst");
        a_in = 12'h123; b_in = 12'h456; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst pre busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst sum_out", sum_out, 0);
        chk("rst in_ready", in_ready, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst release in_ready", in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            chk("rst no output", out_valid, 0);
            tick();
        end
        run_op(12'h123, 12'h456, 1'b0, 13'h0579, "post_rst");

        // Random regression with stalls; scoreboard checks order and count.
        begin
            logic [W:0] q[$];
            int accepts = 0, outs = 0, cyc = 0;
            logic acc_now, done_now;
            logic [W:0] seen;
            in_valid = 1'b0;
            while (outs < 1000 && cyc < 60000) begin
                if (!in_valid && accepts < 1000 && $urandom_range(0, 3) != 0) begin
                    a_in = W'($urandom);
                    b_in = W'($urandom);
                    sub  = 1'($urandom);
                    in_valid = 1'b1;
                end
                out_ready = ($urandom_range(0, 2) != 0);
                acc_now  = in_valid && in_ready;
                done_now = out_valid && out_ready;
                seen = sum_out;
                if (acc_now) q.push_back(model(a_in, b_in, sub));
                tick();
                cyc++;
                if (acc_now) begin
                    accepts++;
                    in_valid = 1'b0;
                end
                if (done_now) begin
                    outs++;
                    if (q.size() == 0) chk("rand unexpected output", 1, 0);
                    else chk($sformatf("rand op%0d", outs), seen, q.pop_front());
                end
            end
            in_valid = 1'b0;
            chk("rand outputs", outs, 1000);
            chk("rand accepts", accepts, 1000);
            chk("rand leftover", q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
